potato2_control: RTL and testbench
==================================

Name: potato2_control

Overview:
- Parametrised second-generation Potato control unit.
- Decodes 4-bit Brainfuck-style opcodes into single-cycle X/A/PC step strobes and held Put/Get requests.
- Sits between the external instruction store / PC / tape datapath and the IO port.
- New over gen-1: single clock edge, repeat-count operand on X/A ops, Put/Get request/ack handshake, parametrised nesting depth with sticky overflow error, halt and error status outputs.

Parameters:
LOOPCTR_W, 16, width of loop-nesting depth counter (max depth 2^LOOPCTR_W-1)
REP_W, 4, width of repeat operand; X/A ops execute Rep+1 times

Ports:
Clock  in  1  system clock; all state on rising edge
Reset_n  in  1  asynchronous active-low reset
Instr  in  4  opcode at current PC
Rep  in  REP_W  repeat operand accompanying Instr
InstrValid  in  1  Instr/Rep valid this cycle
Zero  in  1  current tape cell == 0
IoAck  in  1  IO side completed Put/Get
PcInc, PcDec  out  1  PC step strobes
XInc, XDec, AInc, ADec  out  1  pointer/cell step strobes
Put, Get  out  1  IO requests, held until ack
Halted  out  1  halt reached
Error  out  1  nesting overflow, sticky

Behaviour:
- All outputs are registered. Reset (async, mid-operation included) clears every output to 0, state=RUN, depth=0, rep count=0, fetch-bubble flag=0.
- Opcode map: 0 X+, 1 X-, 2 A+, 3 A-, 4 Put, 5 Get, 6 '[', 7 ']', F halt, 8-E NOP.
- Fetch bubble: the posedge after any PcInc/PcDec pulse ignores Instr, so the external PC/ROM can settle. No other output changes on that edge.
- Instr is consumed only when InstrValid=1, no bubble, and state ∈ {RUN, SCAN_FWD, SCAN_BACK}. Otherwise the block holds state and step outputs are 0.
- Strobes are one cycle wide. Put/Get are levels.
- States: RUN, REPEAT, IO_WAIT, SCAN_FWD, SCAN_BACK, HALT, ERROR.
- RUN transitions by opcode:
  - X/A op: pulse op. If Rep=0, also pulse PcInc. Else latch remaining=Rep and go REPEAT.
  - Put/Get: raise Put/Get, go IO_WAIT.
  - '[' with Zero=0: PcInc.
  - '[' with Zero=1: depth=1, PcInc, go SCAN_FWD.
  - ']' with Zero=1: PcInc.
  - ']' with Zero=0: depth=1, PcDec, go SCAN_BACK.
  - NOP: PcInc.
  - F: all 0, Halted=1, go HALT.
- REPEAT: pulse latched op every cycle and decrement remaining. The cycle remaining goes 1→0 also pulses PcInc and returns to RUN. Total op pulses = Rep+1 on consecutive cycles. Instr/Zero/IoAck are ignored.
- IO_WAIT: hold Put/Get. On the edge sampling IoAck=1, drop Put/Get, pulse PcInc, return to RUN. Minimum request width is 1 cycle; ack may already be high on the first IO_WAIT edge.
- SCAN_FWD: each consumed instr pulses PcInc.
  - '[': depth+1.
  - ']': depth-1. When depth reaches 0, return to RUN; execution continues after the ']'.
  - All other opcodes, including F, are skipped. Rep is ignored.
- SCAN_BACK: mirror of SCAN_FWD with PcDec.
  - ']': depth+1.
  - '[': depth-1. On reaching 0, pulse PcInc instead of PcDec and return to RUN. The matching '[' is not re-evaluated.
- Overflow: an opener ('[' fwd, ']' back) at depth=2^LOOPCTR_W-1 goes to ERROR with Error=1 and no PC step.
- HALT and ERROR are absorbing until reset. In both, all strobe/IO outputs are 0.
- Zero is sampled only on '['/']' in RUN. IoAck outside IO_WAIT is ignored.

Decomposition:
- Shared package potato_pkg holds:
  - opcode constants (OP_XINC … OP_HALT);
  - state enum;
  - command-bit index constants, in the same order as the gen-1 command byte (PC inc/dec, X, A, Put, Get).
- One natural sub-module: potato2_loop_scan. It holds the depth counter, the open/close compare, overflow detect, and direction. The FSM owns RUN/REPEAT/IO_WAIT/HALT.

Test Plan:
- Reset then Instr=2, Rep=3, Zero=0 → AInc high 4 consecutive cycles; PcInc only in the 4th; next edge ignored (bubble).
- Instr=4 → Put rises next edge, held 5 cycles with IoAck=0; IoAck=1 for 1 cycle → Put falls, PcInc 1 pulse; PcDec never asserted.
- Program "[ [ + ] ] x" with Zero=1 at first '[' → SCAN_FWD, 5 PcInc pulses, depth 1→2→1→0, RUN resumes at x; no AInc emitted.
- ']' with Zero=0 after "[ + ]" → PcDec steps back over '+' to '[', then single PcInc; next consumed opcode is '+'; no re-evaluation of '['.
- LOOPCTR_W=2, Zero=1, 4 nested '[' → depth reaches 3, 4th '[' → Error=1, no PC pulse, outputs stay 0 for 10 cycles; Reset_n low mid-ERROR → Error=0, all outputs 0 asynchronously.
- Instr=F during RUN → Halted=1 permanently; Instr=F inside SCAN_FWD → skipped with PcInc, Halted stays 0.

Source files
------------

// File: rtl/potato_pkg.sv
// Shared definitions for the gen-2 Potato control unit: opcodes, FSM states
// and the command-bit layout used to build the registered step/IO outputs.
package potato_pkg;

    localparam logic [3:0] OP_XINC       = 4'h0;
    localparam logic [3:0] OP_XDEC       = 4'h1;
    localparam logic [3:0] OP_AINC       = 4'h2;
    localparam logic [3:0] OP_ADEC       = 4'h3;
    localparam logic [3:0] OP_PUT        = 4'h4;
    localparam logic [3:0] OP_GET        = 4'h5;
    localparam logic [3:0] OP_LOOP_OPEN  = 4'h6;
    localparam logic [3:0] OP_LOOP_CLOSE = 4'h7;
    localparam logic [3:0] OP_HALT       = 4'hF;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_REPEAT,
        ST_IO_WAIT,
        ST_SCAN_FWD,
        ST_SCAN_BACK,
        ST_HALT,
        ST_ERROR
    } state_t;

    // Bit order follows the gen-1 command byte so existing decoders still line up.
    localparam int CMD_PC_INC = 0;
    localparam int CMD_PC_DEC = 1;
    localparam int CMD_X_INC  = 2;
    localparam int CMD_X_DEC  = 3;
    localparam int CMD_A_INC  = 4;
    localparam int CMD_A_DEC  = 5;
    localparam int CMD_PUT    = 6;
    localparam int CMD_GET    = 7;
    localparam int CMD_W      = 8;

    function automatic logic [CMD_W-1:0] opToCmd(input logic [3:0] op);
        logic [CMD_W-1:0] cmd;
        cmd = '0;
        case (op)
            OP_XINC: cmd[CMD_X_INC] = 1'b1;
            OP_XDEC: cmd[CMD_X_DEC] = 1'b1;
            OP_AINC: cmd[CMD_A_INC] = 1'b1;
            OP_ADEC: cmd[CMD_A_DEC] = 1'b1;
            default: cmd = '0;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/potato2_loop_scan.sv
// Loop-nesting tracker used while skipping over a loop body in either
// direction: depth counter, opener/closer classification and overflow detect.
module potato2_loop_scan
    import potato_pkg::*;
#(
    parameter int LOOPCTR_W = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_startFwd,
    input  logic       i_startBack,
    input  logic       i_step,
    input  logic [3:0] i_instr,
    output logic       o_backward,
    output logic       o_open,
    output logic       o_close,
    output logic       o_overflow,
    output logic       o_lastClose
);

    localparam logic [LOOPCTR_W-1:0] DEPTH_MAX = '1;
    localparam logic [LOOPCTR_W-1:0] DEPTH_ONE = LOOPCTR_W'(1);

    logic [LOOPCTR_W-1:0] r_depth;
    logic                 r_backward;
    logic                 w_isOpenBracket;
    logic                 w_isCloseBracket;

    assign w_isOpenBracket  = (i_instr == OP_LOOP_OPEN);
    assign w_isCloseBracket = (i_instr == OP_LOOP_CLOSE);

    // Scanning backward swaps the roles of '[' and ']'.
    assign o_open      = r_backward ? w_isCloseBracket : w_isOpenBracket;
    assign o_close     = r_backward ? w_isOpenBracket  : w_isCloseBracket;
    assign o_overflow  = o_open && (r_depth == DEPTH_MAX);
    assign o_lastClose = o_close && (r_depth == DEPTH_ONE);
    assign o_backward  = r_backward;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_depth    <= '0;
            r_backward <= 1'b0;
        end else if (i_startFwd) begin
            r_depth    <= DEPTH_ONE;
            r_backward <= 1'b0;
        end else if (i_startBack) begin
            r_depth    <= DEPTH_ONE;
            r_backward <= 1'b1;
        end else if (i_step) begin
            if (o_open && !o_overflow) begin
                r_depth <= r_depth + DEPTH_ONE;
            end else if (o_close) begin
                r_depth <= r_depth - DEPTH_ONE;
            end
        end
    end

endmodule

// File: rtl/potato2_control.sv
// Gen-2 Potato control unit: decodes one opcode per fetch into registered
// PC/X/A step strobes, held Put/Get requests, and halt/error status.
module potato2_control
    import potato_pkg::*;
#(
    parameter int LOOPCTR_W = 16,
    parameter int REP_W     = 4
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [3:0]       Instr,
    input  logic [REP_W-1:0] Rep,
    input  logic             InstrValid,
    input  logic             Zero,
    input  logic             IoAck,
    output logic             PcInc,
    output logic             PcDec,
    output logic             XInc,
    output logic             XDec,
    output logic             AInc,
    output logic             ADec,
    output logic             Put,
    output logic             Get,
    output logic             Halted,
    output logic             Error
);

    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    state_t           r_state;
    logic [CMD_W-1:0] r_cmd;
    logic [CMD_W-1:0] r_repCmd;
    logic [REP_W-1:0] r_remaining;
    logic             r_halted;
    logic             r_error;

    logic w_bubble;
    logic w_consume;
    logic w_inScan;
    logic w_startFwd;
    logic w_startBack;
    logic w_scanStep;
    logic w_backward;
    logic w_open;
    logic w_close;
    logic w_overflow;
    logic w_lastClose;

    // A PC step on the previous edge means the ROM output is still stale.
    assign w_bubble    = r_cmd[CMD_PC_INC] | r_cmd[CMD_PC_DEC];
    assign w_inScan    = (r_state == ST_SCAN_FWD) || (r_state == ST_SCAN_BACK);
    assign w_consume   = InstrValid && !w_bubble && ((r_state == ST_RUN) || w_inScan);
    assign w_startFwd  = w_consume && (r_state == ST_RUN) && (Instr == OP_LOOP_OPEN) && Zero;
    assign w_startBack = w_consume && (r_state == ST_RUN) && (Instr == OP_LOOP_CLOSE) && !Zero;
    assign w_scanStep  = w_consume && w_inScan;

    potato2_loop_scan #(
        .LOOPCTR_W (LOOPCTR_W)
    ) u_loopScan (
        .i_clk       (Clock),
        .i_rst_n     (Reset_n),
        .i_startFwd  (w_startFwd),
        .i_startBack (w_startBack),
        .i_step      (w_scanStep),
        .i_instr     (Instr),
        .o_backward  (w_backward),
        .o_open      (w_open),
        .o_close     (w_close),
        .o_overflow  (w_overflow),
        .o_lastClose (w_lastClose)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_RUN;
            r_cmd       <= '0;
            r_repCmd    <= '0;
            r_remaining <= '0;
            r_halted    <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_cmd <= '0;
            case (r_state)
                ST_RUN: begin
                    if (w_consume) begin
                        case (Instr)
                            OP_XINC, OP_XDEC, OP_AINC, OP_ADEC: begin
                                r_cmd <= opToCmd(Instr);
                                if (Rep == '0) begin
                                    r_cmd[CMD_PC_INC] <= 1'b1;
                                end else begin
                                    r_repCmd    <= opToCmd(Instr);
                                    r_remaining <= Rep;
                                    r_state     <= ST_REPEAT;
                                end
                            end
                            OP_PUT: begin
                                r_cmd[CMD_PUT] <= 1'b1;
                                r_state        <= ST_IO_WAIT;
                            end
                            OP_GET: begin
                                r_cmd[CMD_GET] <= 1'b1;
                                r_state        <= ST_IO_WAIT;
                            end
                            OP_LOOP_OPEN: begin
                                r_cmd[CMD_PC_INC] <= 1'b1;
                                if (Zero) begin
                                    r_state <= ST_SCAN_FWD;
                                end
                            end
                            OP_LOOP_CLOSE: begin
                                if (Zero) begin
                                    r_cmd[CMD_PC_INC] <= 1'b1;
                                end else begin
                                    r_cmd[CMD_PC_DEC] <= 1'b1;
                                    r_state           <= ST_SCAN_BACK;
                                end
                            end
                            OP_HALT: begin
                                r_halted <= 1'b1;
                                r_state  <= ST_HALT;
                            end
                            default: begin
                                r_cmd[CMD_PC_INC] <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_REPEAT: begin
                    r_cmd       <= r_repCmd;
                    r_remaining <= r_remaining - REP_ONE;
                    if (r_remaining == REP_ONE) begin
                        r_cmd[CMD_PC_INC] <= 1'b1;
                        r_state           <= ST_RUN;
                    end
                end
                ST_IO_WAIT: begin
                    if (IoAck) begin
                        r_cmd[CMD_PC_INC] <= 1'b1;
                        r_state           <= ST_RUN;
                    end else begin
                        r_cmd[CMD_PUT] <= r_cmd[CMD_PUT];
                        r_cmd[CMD_GET] <= r_cmd[CMD_GET];
                    end
                end
                // Matching '[' found backward resumes just after it, hence PcInc.
                ST_SCAN_FWD, ST_SCAN_BACK: begin
                    if (w_scanStep) begin
                        if (w_overflow) begin
                            r_error <= 1'b1;
                            r_state <= ST_ERROR;
                        end else if (w_lastClose) begin
                            r_cmd[CMD_PC_INC] <= 1'b1;
                            r_state           <= ST_RUN;
                        end else begin
                            r_cmd[w_backward ? CMD_PC_DEC : CMD_PC_INC] <= 1'b1;
                        end
                    end
                end
                ST_HALT, ST_ERROR: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= ST_ERROR;
                    r_error <= 1'b1;
                end
            endcase
        end
    end

    assign PcInc  = r_cmd[CMD_PC_INC];
    assign PcDec  = r_cmd[CMD_PC_DEC];
    assign XInc   = r_cmd[CMD_X_INC];
    assign XDec   = r_cmd[CMD_X_DEC];
    assign AInc   = r_cmd[CMD_A_INC];
    assign ADec   = r_cmd[CMD_A_DEC];
    assign Put    = r_cmd[CMD_PUT];
    assign Get    = r_cmd[CMD_GET];
    assign Halted = r_halted;
    assign Error  = r_error;

endmodule

// File: tb/tb_potato2_control.sv
// Directed bench for potato2_control: expected output vectors are queued as
// each step is driven and compared one cycle later against the DUT outputs.
module tb_potato2_control;

    localparam logic [3:0] I_XI  = 4'h0;
    localparam logic [3:0] I_XD  = 4'h1;
    localparam logic [3:0] I_AI  = 4'h2;
    localparam logic [3:0] I_AD  = 4'h3;
    localparam logic [3:0] I_PUT = 4'h4;
    localparam logic [3:0] I_GET = 4'h5;
    localparam logic [3:0] I_OPN = 4'h6;
    localparam logic [3:0] I_CLS = 4'h7;
    localparam logic [3:0] I_NOP = 4'h9;
    localparam logic [3:0] I_HLT = 4'hF;

    // Packed as {Error, Halted, Get, Put, ADec, AInc, XDec, XInc, PcDec, PcInc}.
    localparam logic [9:0] E_NONE = 10'h000;
    localparam logic [9:0] E_PCI  = 10'h001;
    localparam logic [9:0] E_PCD  = 10'h002;
    localparam logic [9:0] E_XI   = 10'h004;
    localparam logic [9:0] E_XD   = 10'h008;
    localparam logic [9:0] E_AI   = 10'h010;
    localparam logic [9:0] E_AD   = 10'h020;
    localparam logic [9:0] E_PUT  = 10'h040;
    localparam logic [9:0] E_GET  = 10'h080;
    localparam logic [9:0] E_HLT  = 10'h100;
    localparam logic [9:0] E_ERR  = 10'h200;

    logic       Clock;
    logic       Reset_n;
    logic [3:0] Instr;
    logic [3:0] Rep;
    logic       InstrValid;
    logic       Zero;
    logic       IoAck;
    logic       PcInc, PcDec, XInc, XDec, AInc, ADec, Put, Get, Halted, Error;

    logic [9:0] expQ[$];
    string      tagQ[$];
    int         checks;
    int         failures;

    potato2_control #(
        .LOOPCTR_W (2),
        .REP_W     (4)
    ) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Instr      (Instr),
        .Rep        (Rep),
        .InstrValid (InstrValid),
        .Zero       (Zero),
        .IoAck      (IoAck),
        .PcInc      (PcInc),
        .PcDec      (PcDec),
        .XInc       (XInc),
        .XDec       (XDec),
        .AInc       (AInc),
        .ADec       (ADec),
        .Put        (Put),
        .Get        (Get),
        .Halted     (Halted),
        .Error      (Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput();
        logic [9:0] obs;
        logic [9:0] exp;
        string      tag;
        obs = {Error, Halted, Get, Put, ADec, AInc, XDec, XInc, PcDec, PcInc};
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%b expected=<none>", obs);
        end else begin
            exp = expQ.pop_front();
            tag = tagQ.pop_front();
            assert (obs === exp) else begin
                failures++;
                $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [3:0] rep,
                                 input logic z, input logic ack, input logic [9:0] exp,
                                 input string tag);
        InstrValid = v;
        Instr      = op;
        Rep        = rep;
        Zero       = z;
        IoAck      = ack;
        expQ.push_back(exp);
        tagQ.push_back(tag);
        @(posedge Clock);
        #1;
        checkOutput();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        Reset_n    = 1'b0;
        InstrValid = 1'b0;
        Instr      = 4'h0;
        Rep        = 4'h0;
        Zero       = 1'b0;
        IoAck      = 1'b0;
        #12;
        expQ.push_back(E_NONE);
        tagQ.push_back("reset_state");
        checkOutput();
        @(negedge Clock);
        Reset_n = 1'b1;
        $display("[TB] reset released");

        // A+ repeated 4 times, PcInc on the last, then a fetch bubble
        applyStimulus(1, I_AI, 4'd3, 0, 0, E_AI,          "rep_a_1");
        applyStimulus(1, I_XI, 4'd0, 1, 1, E_AI,          "rep_a_2");
        applyStimulus(1, I_XI, 4'd0, 1, 1, E_AI,          "rep_a_3");
        applyStimulus(1, I_XI, 4'd0, 1, 1, E_AI | E_PCI,  "rep_a_4");
        applyStimulus(1, I_XI, 4'd0, 0, 0, E_NONE,        "rep_bubble");

        // Put held until ack
        applyStimulus(1, I_PUT, 4'd0, 0, 0, E_PUT,        "put_rise");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_PUT,        "put_hold_1");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_PUT,        "put_hold_2");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_PUT,        "put_hold_3");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_PUT,        "put_hold_4");
        applyStimulus(1, I_XI,  4'd0, 0, 1, E_PCI,        "put_ack");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "put_bubble");

        // Get with ack already high: ignored in RUN, accepted on first wait edge
        applyStimulus(1, I_GET, 4'd0, 0, 1, E_GET,        "get_rise");
        applyStimulus(1, I_XI,  4'd0, 0, 1, E_PCI,        "get_ack");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "get_bubble");

        // Simple decodes
        applyStimulus(1, I_NOP, 4'd0, 0, 0, E_PCI,        "nop");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "nop_bubble");
        applyStimulus(1, I_XD,  4'd0, 0, 0, E_XD | E_PCI, "xdec_rep0");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "xdec_bubble");
        applyStimulus(1, I_XI,  4'd1, 0, 0, E_XI,         "xinc_rep1_a");
        applyStimulus(1, I_AD,  4'd0, 0, 0, E_XI | E_PCI, "xinc_rep1_b");
        applyStimulus(1, I_AD,  4'd0, 0, 0, E_NONE,       "xinc_bubble");
        applyStimulus(1, I_AD,  4'd0, 0, 0, E_AD | E_PCI, "adec_rep0");
        applyStimulus(0, I_XI,  4'd0, 0, 0, E_NONE,       "adec_bubble");
        applyStimulus(0, I_XI,  4'd0, 0, 0, E_NONE,       "invalid_hold");
        applyStimulus(1, I_OPN, 4'd0, 0, 0, E_PCI,        "open_nonzero");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "open_bubble");
        applyStimulus(1, I_CLS, 4'd0, 1, 0, E_PCI,        "close_zero");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "close_bubble");

        // Forward scan over "[ [ + ] ] x"
        applyStimulus(1, I_OPN, 4'd0, 1, 0, E_PCI,        "fwd_open1");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "fwd_b1");
        applyStimulus(1, I_OPN, 4'd0, 0, 0, E_PCI,        "fwd_open2");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "fwd_b2");
        applyStimulus(1, I_AI,  4'd0, 0, 0, E_PCI,        "fwd_skip_plus");
        applyStimulus(0, I_XI,  4'd0, 0, 0, E_NONE,       "fwd_b3");
        applyStimulus(0, I_CLS, 4'd0, 0, 0, E_NONE,       "fwd_invalid");
        applyStimulus(1, I_CLS, 4'd0, 0, 0, E_PCI,        "fwd_close1");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "fwd_b4");
        applyStimulus(1, I_CLS, 4'd0, 0, 0, E_PCI,        "fwd_close2");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "fwd_b5");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_XI | E_PCI, "fwd_resume_x");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "fwd_b6");

        // Halt opcode inside a forward scan is skipped
        applyStimulus(1, I_OPN, 4'd0, 1, 0, E_PCI,        "fwdh_open");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "fwdh_b1");
        applyStimulus(1, I_HLT, 4'd0, 0, 0, E_PCI,        "fwdh_skip_halt");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "fwdh_b2");
        applyStimulus(1, I_CLS, 4'd0, 0, 0, E_PCI,        "fwdh_close");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "fwdh_b3");

        // Backward scan over "[ + ]"
        applyStimulus(1, I_OPN, 4'd0, 0, 0, E_PCI,        "bk_open");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "bk_b1");
        applyStimulus(1, I_AI,  4'd0, 0, 0, E_AI | E_PCI, "bk_plus");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "bk_b2");
        applyStimulus(1, I_CLS, 4'd0, 0, 0, E_PCD,        "bk_close");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "bk_b3");
        applyStimulus(1, I_AI,  4'd0, 0, 0, E_PCD,        "bk_skip_plus");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "bk_b4");
        applyStimulus(1, I_OPN, 4'd0, 1, 0, E_PCI,        "bk_match_open");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "bk_b5");
        applyStimulus(1, I_AI,  4'd0, 0, 0, E_AI | E_PCI, "bk_resume_plus");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "bk_b6");

        // Nested backward scan "[ [ ] ]" starting from the outer ']'
        applyStimulus(1, I_CLS, 4'd0, 0, 0, E_PCD,        "bkn_close_outer");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "bkn_b1");
        applyStimulus(1, I_CLS, 4'd0, 0, 0, E_PCD,        "bkn_close_inner");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "bkn_b2");
        applyStimulus(1, I_OPN, 4'd0, 0, 0, E_PCD,        "bkn_open_inner");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "bkn_b3");
        applyStimulus(1, I_OPN, 4'd0, 0, 0, E_PCI,        "bkn_open_outer");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "bkn_b4");

        // Nesting overflow with a 2-bit depth counter
        applyStimulus(1, I_OPN, 4'd0, 1, 0, E_PCI,        "ovf_open1");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "ovf_b1");
        applyStimulus(1, I_OPN, 4'd0, 1, 0, E_PCI,        "ovf_open2");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "ovf_b2");
        applyStimulus(1, I_OPN, 4'd0, 1, 0, E_PCI,        "ovf_open3");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "ovf_b3");
        applyStimulus(1, I_OPN, 4'd0, 1, 0, E_ERR,        "ovf_open4");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 4'(i), 4'(i), i[0], 1'b1, E_ERR, "err_sticky");
        end

        // Asynchronous reset in the middle of ERROR
        #2;
        Reset_n = 1'b0;
        #1;
        expQ.push_back(E_NONE);
        tagQ.push_back("async_reset_in_error");
        checkOutput();
        @(negedge Clock);
        Reset_n = 1'b1;

        // Halt is absorbing
        applyStimulus(1, I_NOP, 4'd0, 0, 0, E_PCI,        "post_reset_nop");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_NONE,       "post_reset_bubble");
        applyStimulus(1, I_HLT, 4'd0, 0, 0, E_HLT,        "halt");
        applyStimulus(1, I_XI,  4'd0, 0, 0, E_HLT,        "halt_hold_x");
        applyStimulus(1, I_PUT, 4'd0, 0, 1, E_HLT,        "halt_hold_put");
        applyStimulus(1, I_CLS, 4'd0, 0, 0, E_HLT,        "halt_hold_close");
        applyStimulus(1, I_AI,  4'd5, 1, 1, E_HLT,        "halt_hold_rep");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
